// File: rtl/ita_weight_ring_controller.sv
// ita_weight_ring_controller
// N-bank ring of weight tiles between the weight streamer and the PE array.
// The write side assembles a tile from N_WRITE_EN beats into the bank at
// write_addr; the read side presents the bank at read_addr for a latched
// number of reads, then frees it. Status bits are updated only on clock
// edges, so a freshly filled bank becomes visible one cycle after its last
// beat. There is no combinational path from the write side to the read side.
//
// state    | meaning
// status_q | one bit per bank: 1 = full tile waiting to be read
// next_q   | lane that the next accepted beat lands in
// cnt_q    | reads already taken from the current read bank
// limit_q  | read limit latched at the first read of the current tile
module ita_weight_ring_controller #(
  parameter int unsigned N_BUF      = 3,
  parameter int unsigned N_WRITE_EN = 4,
  parameter int unsigned WW         = 64,
  parameter int unsigned MAX_READS  = 64,
  localparam int unsigned RW = $clog2(MAX_READS + 1),
  localparam int unsigned AW = (N_BUF > 1) ? $clog2(N_BUF) : 1,
  localparam int unsigned OW = $clog2(N_BUF + 1),
  localparam int unsigned LW = $clog2(N_WRITE_EN)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic [RW-1:0]            reads_per_tile_i,
  input  logic                     inp_weight_valid_i,
  output logic                     inp_weight_ready_o,
  input  logic [WW-1:0]            inp_weight_i,
  output logic                     write_en_o,
  output logic [AW-1:0]            write_addr_o,
  output logic [N_WRITE_EN*WW-1:0] write_data_o,
  output logic [N_WRITE_EN-1:0]    write_select_o,
  output logic                     weight_valid_o,
  input  logic                     weight_ready_i,
  output logic                     read_en_o,
  output logic [AW-1:0]            read_addr_o,
  output logic [OW-1:0]            occupancy_o
);

  logic [N_BUF-1:0] status_q, status_d;
  logic [AW-1:0]    write_addr_q, write_addr_d;
  logic [AW-1:0]    read_addr_q, read_addr_d;
  logic [LW-1:0]    next_q, next_d;
  logic [RW-1:0]    cnt_q, cnt_d;
  logic [RW-1:0]    limit_q, limit_d;
  logic [OW-1:0]    occ_q, occ_d;

  logic          wr_hs;
  logic          fill;
  logic          free;
  logic [RW-1:0] reads_eff;
  logic [RW-1:0] cur_limit;

  // Handshakes; clear_i masks both sides in the cycle it is asserted.
  assign inp_weight_ready_o = ~status_q[write_addr_q] & ~clear_i;
  assign wr_hs              = inp_weight_valid_i & inp_weight_ready_o;
  assign write_en_o         = wr_hs;
  assign write_addr_o       = write_addr_q;

  assign weight_valid_o = status_q[read_addr_q] & ~clear_i;
  assign read_en_o      = weight_valid_o & weight_ready_i;
  assign read_addr_o    = read_addr_q;
  assign occupancy_o    = occ_q;

  // A programmed limit of 0 behaves as 1. The limit in force for a tile is
  // the one sampled at its first read, so later changes cannot cut it short.
  assign reads_eff = (reads_per_tile_i == '0) ? RW'(1) : reads_per_tile_i;
  assign cur_limit = (cnt_q == '0) ? reads_eff : limit_q;

  assign fill = wr_hs & (next_q == LW'(N_WRITE_EN - 1));
  assign free = read_en_o & ((cnt_q + RW'(1)) == cur_limit);

  for (genvar g = 0; g < N_WRITE_EN; g++) begin : g_lane
    assign write_select_o[g]         = wr_hs & (next_q == LW'(g));
    assign write_data_o[g*WW +: WW]  = write_select_o[g] ? inp_weight_i : '0;
  end

  // Next-state: write pointer/lane, read count/limit, bank status, occupancy.
  always_comb begin
    status_d     = status_q;
    write_addr_d = write_addr_q;
    read_addr_d  = read_addr_q;
    next_d       = next_q;
    cnt_d        = cnt_q;
    limit_d      = limit_q;
    occ_d        = occ_q;
    if (clear_i) begin
      status_d     = '0;
      write_addr_d = '0;
      read_addr_d  = '0;
      next_d       = '0;
      cnt_d        = '0;
      limit_d      = '0;
      occ_d        = '0;
    end else begin
      if (wr_hs) begin
        // N_WRITE_EN is a power of two, so the lane pointer wraps by overflow.
        next_d = next_q + LW'(1);
      end
      if (fill) begin
        status_d[write_addr_q] = 1'b1;
        write_addr_d = (write_addr_q == AW'(N_BUF - 1)) ? '0 : write_addr_q + AW'(1);
      end
      if (read_en_o) begin
        if (cnt_q == '0) begin
          limit_d = reads_eff;
        end
        cnt_d = free ? '0 : cnt_q + RW'(1);
      end
      // Fill and free never target the same bank in one cycle (fill needs
      // an empty bank, free a full one), so both updates can apply.
      if (free) begin
        status_d[read_addr_q] = 1'b0;
        read_addr_d = (read_addr_q == AW'(N_BUF - 1)) ? '0 : read_addr_q + AW'(1);
      end
      case ({fill, free})
        2'b10:   occ_d = occ_q + OW'(1);
        2'b01:   occ_d = occ_q - OW'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      status_q     <= '0;
      write_addr_q <= '0;
      read_addr_q  <= '0;
      next_q       <= '0;
      cnt_q        <= '0;
      limit_q      <= '0;
      occ_q        <= '0;
    end else begin
      status_q     <= status_d;
      write_addr_q <= write_addr_d;
      read_addr_q  <= read_addr_d;
      next_q       <= next_d;
      cnt_q        <= cnt_d;
      limit_q      <= limit_d;
      occ_q        <= occ_d;
    end
  end

endmodule

// File: tb/tb_ita_weight_ring_controller.sv
// Directed, table-driven bench for ita_weight_ring_controller (N_BUF=3,
// N_WRITE_EN=4). Each table row is one clock cycle: inputs are applied after
// the rising edge, and outputs are compared on the falling edge.
module tb_ita_weight_ring_controller;
  localparam int NB = 3;
  localparam int NW = 4;
  localparam int WW = 64;
  localparam int MR = 64;
  localparam int RW = $clog2(MR + 1);

  logic              clk_i;
  logic              rst_ni;
  logic              clear_i;
  logic [RW-1:0]     reads_per_tile_i;
  logic              inp_weight_valid_i;
  logic              inp_weight_ready_o;
  logic [WW-1:0]     inp_weight_i;
  logic              write_en_o;
  logic [1:0]        write_addr_o;
  logic [NW*WW-1:0]  write_data_o;
  logic [NW-1:0]     write_select_o;
  logic              weight_valid_o;
  logic              weight_ready_i;
  logic              read_en_o;
  logic [1:0]        read_addr_o;
  logic [1:0]        occupancy_o;

  ita_weight_ring_controller #(
    .N_BUF(NB), .N_WRITE_EN(NW), .WW(WW), .MAX_READS(MR)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .clear_i(clear_i),
    .reads_per_tile_i(reads_per_tile_i),
    .inp_weight_valid_i(inp_weight_valid_i),
    .inp_weight_ready_o(inp_weight_ready_o),
    .inp_weight_i(inp_weight_i),
    .write_en_o(write_en_o),
    .write_addr_o(write_addr_o),
    .write_data_o(write_data_o),
    .write_select_o(write_select_o),
    .weight_valid_o(weight_valid_o),
    .weight_ready_i(weight_ready_i),
    .read_en_o(read_en_o),
    .read_addr_o(read_addr_o),
    .occupancy_o(occupancy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    string    name;
    bit       clr, vld, rdy;
    int       reads;
    bit       ro, we;
    bit [3:0] ws;
    int       wa;
    bit       wv, re;
    int       ra, oc;
  } vec_t;

  vec_t vq[$];
  int checks = 0;
  int failures = 0;

  task automatic add(input string n, input bit clr, input bit vld, input bit rdy, input int reads,
                     input bit ro, input bit we, input bit [3:0] ws, input int wa,
                     input bit wv, input bit re, input int ra, input int oc);
    vec_t v;
    v.name = n; v.clr = clr; v.vld = vld; v.rdy = rdy; v.reads = reads;
    v.ro = ro; v.we = we; v.ws = ws; v.wa = wa; v.wv = wv; v.re = re; v.ra = ra; v.oc = oc;
    vq.push_back(v);
  endtask

  // Four beats of one tile with the consumer idle; occupancy only moves after the last beat.
  task automatic add_tile(input string n, input int wa, input int oc, input bit wv, input int ra);
    for (int k = 0; k < 4; k++) begin
      bit [3:0] sel;
      sel = 4'(1 << k);
      add(n, 0, 1, 0, 5, 1, 1, sel, wa, wv, 0, ra, oc);
    end
  endtask

  task automatic chk(input string n, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  initial begin
    logic [13:0]  act_s, exp_s;
    logic [255:0] exp_d;

    // reset state
    add("reset", 0,0,0,5, 1,0,4'b0000,0, 0,0,0,0);
    // first tile: lanes 0..3, visible the cycle after the last beat
    add("t0b0", 0,1,0,5, 1,1,4'b0001,0, 0,0,0,0);
    add("t0b1", 0,1,0,5, 1,1,4'b0010,0, 0,0,0,0);
    add("t0b2", 0,1,0,5, 1,1,4'b0100,0, 0,0,0,0);
    add("t0b3", 0,1,0,5, 1,1,4'b1000,0, 0,0,0,0);
    add("t0vld", 0,0,0,5, 1,0,4'b0000,1, 1,0,0,1);
    // fill to full, write_addr wraps to 0, incoming beat stalls
    add_tile("fill1", 1, 1, 1, 0);
    add_tile("fill2", 2, 2, 1, 0);
    add("full_stall", 0,1,0,5, 0,0,4'b0000,0, 1,0,0,3);
    // limit latched at 5 on first read, later change to 2 ignored
    add("rd1", 0,1,1,5, 0,0,4'b0000,0, 1,1,0,3);
    for (int k = 0; k < 4; k++) add("rd_lim", 0,1,1,2, 0,0,4'b0000,0, 1,1,0,3);
    add("freed0", 0,0,0,5, 1,0,4'b0000,0, 1,0,1,2);
    // next tile uses the new limit of 2
    add("b1rd", 0,0,1,2, 1,0,4'b0000,0, 1,1,1,2);
    add("b1rd", 0,0,1,2, 1,0,4'b0000,0, 1,1,1,2);
    // reads_per_tile_i = 0 -> single read frees the bank
    add("b2rd0", 0,0,1,0, 1,0,4'b0000,0, 1,1,2,1);
    add("empty", 0,0,1,0, 1,0,4'b0000,0, 0,0,0,0);
    add_tile("z0", 0, 0, 0, 0);
    add_tile("z1", 1, 1, 1, 0);
    add_tile("z2", 2, 2, 1, 0);
    add("z_rd0", 0,0,1,0, 0,0,4'b0000,0, 1,1,0,3);
    add("z_rd1", 0,0,1,0, 1,0,4'b0000,0, 1,1,1,2);
    add("z_rd2", 0,0,1,0, 1,0,4'b0000,0, 1,1,2,1);
    add("z_empty", 0,0,1,0, 1,0,4'b0000,0, 0,0,0,0);
    // last beat of bank 1 coincides with last (3rd) read of bank 0
    add_tile("s0", 0, 0, 0, 0);
    add("s1b0", 0,1,0,3, 1,1,4'b0001,1, 1,0,0,1);
    add("s1b1", 0,1,1,3, 1,1,4'b0010,1, 1,1,0,1);
    add("s1b2", 0,1,1,3, 1,1,4'b0100,1, 1,1,0,1);
    add("s1b3", 0,1,1,3, 1,1,4'b1000,1, 1,1,0,1);
    add("swap", 0,0,0,3, 1,0,4'b0000,2, 1,0,1,1);
    // clear with two beats buffered and one full bank
    add("c_b0", 0,1,0,3, 1,1,4'b0001,2, 1,0,1,1);
    add("c_b1", 0,1,0,3, 1,1,4'b0010,2, 1,0,1,1);
    add("clear", 1,1,1,3, 0,0,4'b0000,2, 0,0,1,1);
    add("post_clr", 0,0,0,3, 1,0,4'b0000,0, 0,0,0,0);
    add("pc_b0", 0,1,0,3, 1,1,4'b0001,0, 0,0,0,0);
    add("pc_b1", 0,1,0,3, 1,1,4'b0010,0, 0,0,0,0);
    add("pc_b2", 0,1,0,3, 1,1,4'b0100,0, 0,0,0,0);
    add("pc_b3", 0,1,0,3, 1,1,4'b1000,0, 0,0,0,0);
    add("pc2_b0", 0,1,0,3, 1,1,4'b0001,1, 1,0,0,1);
    add("pc2_b1", 0,1,0,3, 1,1,4'b0010,1, 1,0,0,1);

    rst_ni = 1'b0;
    clear_i = 1'b0;
    reads_per_tile_i = RW'(5);
    inp_weight_valid_i = 1'b0;
    inp_weight_i = '0;
    weight_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      clear_i            = vq[i].clr;
      inp_weight_valid_i = vq[i].vld;
      weight_ready_i     = vq[i].rdy;
      reads_per_tile_i   = RW'(vq[i].reads);
      inp_weight_i       = {32'hA5000000 + 32'(i), 32'(i * 7 + 3)};
      @(negedge clk_i);
      act_s = {inp_weight_ready_o, write_en_o, write_select_o, write_addr_o,
               weight_valid_o, read_en_o, read_addr_o, occupancy_o};
      exp_s = {vq[i].ro, vq[i].we, vq[i].ws, 2'(vq[i].wa),
               vq[i].wv, vq[i].re, 2'(vq[i].ra), 2'(vq[i].oc)};
      chk($sformatf("%s[%0d].ctl", vq[i].name, i), 256'(act_s), 256'(exp_s));
      exp_d = '0;
      for (int k = 0; k < NW; k++) if (vq[i].ws[k]) exp_d[k*WW +: WW] = inp_weight_i;
      chk($sformatf("%s[%0d].data", vq[i].name, i), write_data_o, exp_d);
      @(posedge clk_i);
      #1;
    end

    // async reset in the middle of a tile (bank 0 full, two beats in bank 1)
    inp_weight_valid_i = 1'b0;
    weight_ready_i = 1'b0;
    clear_i = 1'b0;
    rst_ni = 1'b0;
    #2;
    chk("arst.occ", 256'(occupancy_o), 256'(0));
    chk("arst.waddr", 256'(write_addr_o), 256'(0));
    chk("arst.wvalid", 256'(weight_valid_o), 256'(0));
    @(negedge clk_i);
    rst_ni = 1'b1;
    inp_weight_valid_i = 1'b1;
    inp_weight_i = 64'h0123456789ABCDEF;
    #1;
    chk("arst.lane0", 256'({write_en_o, write_select_o, write_addr_o}), 256'({1'b1, 4'b0001, 2'd0}));
    repeat (4) @(posedge clk_i);
    #1 inp_weight_valid_i = 1'b0;
    @(negedge clk_i);
    chk("arst.refill", 256'({occupancy_o, weight_valid_o, read_addr_o, write_addr_o}),
        256'({2'd1, 1'b1, 2'd0, 2'd1}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
